multiplier_middle_bits_seq: RTL and testbench
=============================================

MULTIPLIER_MIDDLE_BITS_SEQ -- requirements
Module: multiplier_middle_bits_seq

Interface
REQ-001 SHALL have parameter MUL_SIZE, default 80, operand width in bits.
REQ-002 SHALL have parameter LIMB, default 20, limb width; MUL_SIZE % LIMB == 0; K = MUL_SIZE/LIMB.
REQ-003 SHALL have parameter N_DSP, default 4, partial products issued per cycle; (K*K) % N_DSP == 0; P = K*K/N_DSP.
REQ-004 SHALL have parameter LO, default 0, lowest product bit returned.
REQ-005 SHALL have parameter OUT_W, default 158, result window width; LO+OUT_W <= 2*MUL_SIZE.
REQ-006 SHALL have port clk, input, 1, single clock, rising edge.
REQ-007 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-008 SHALL have port clear, input, 1, synchronous abort of the operation in flight.
REQ-009 SHALL have port in_valid, input, 1, operands valid.
REQ-010 SHALL have port in_ready, output, 1, block accepts operands.
REQ-011 SHALL have ports a and b, input, MUL_SIZE each, unsigned operands.
REQ-012 SHALL have port out_valid, output, 1, res valid.
REQ-013 SHALL have port out_ready, input, 1, consumer accepts res.
REQ-014 SHALL have port res, output, OUT_W, product bits [LO+OUT_W-1:LO].
REQ-015 SHALL have port busy, output, 1, high in any state other than IDLE.

Function
REQ-016 SHALL implement states IDLE, CALC, DRAIN, DONE.
REQ-017 SHALL drive in_ready = 1 only in IDLE.
REQ-018 SHALL, in IDLE on in_valid&&in_ready, register a and b, clear the 2*MUL_SIZE accumulator, set group index g=0, and enter CALC.
REQ-019 SHALL ignore a/b changes after acceptance and ignore in_valid outside IDLE.
REQ-020 SHALL, in CALC, each cycle compute N_DSP limb products a_i*b_j for flat index p=i*K+j, p in [g*N_DSP, g*N_DSP+N_DSP-1], into 2*LIMB-bit registers; g increments; after g=P-1 enter DRAIN.
REQ-021 SHALL, one cycle after each product register load, add every product shifted left by (i+j)*LIMB into the accumulator.
REQ-022 SHALL form the accumulator sum exactly modulo 2^(2*MUL_SIZE); no truncation before the window select.
REQ-023 SHALL, in DRAIN, perform the final accumulation, load res from accumulator bits [LO+OUT_W-1:LO], and enter DONE.
REQ-024 SHALL assert out_valid in DONE; out_valid rises P+2 cycles after the accepting edge (6 at defaults).
REQ-025 SHALL hold res and out_valid stable in DONE until out_ready=1; on out_valid&&out_ready, return to IDLE next cycle with out_valid=0; res retains its value.
REQ-026 SHALL, on clear=1 in any state, enter IDLE next cycle, drop out_valid, and discard partial results; clear takes priority over in_valid and out_ready.
REQ-027 SHALL not issue back-to-back operations; the earliest next acceptance is the cycle after the DONE handshake.

Reset
REQ-028 SHALL, while rst_n=0 (asynchronous assertion), force state IDLE, out_valid=0, res=0, busy=0, accumulator and product registers 0.
REQ-029 SHALL, after rst_n deasserts, show in_ready=1 and accept operands on the first clock edge with in_valid=1.
REQ-030 SHALL, if reset asserts mid-operation, lose the operation and produce no out_valid for it.

Verification
REQ-031 SHALL check: defaults, a=1, b=1, out_ready=1 -> out_valid at cycle 6, res=1, then in_ready=1 next cycle.
REQ-032 SHALL check: a=b=2^80-1 -> res = 2^158 - 2^81 + 1; with LO=80, OUT_W=80 -> res = 2^80 - 2.
REQ-033 SHALL check: out_ready held 0 for 3 cycles in DONE -> res and out_valid stable, in_ready=0, in_valid pulses ignored.
REQ-034 SHALL check: clear pulsed at cycle 3 of CALC -> IDLE next cycle, no out_valid; next operation a=2^20, b=2^20 -> res=2^40.
REQ-035 SHALL check: rst_n pulled low mid-CALC -> outputs 0 immediately, no stale out_valid after release.
REQ-036 SHALL check: N_DSP=16 and N_DSP=1 at MUL_SIZE=80 -> latency 3 and 18 respectively; 1000 random operands match a reference product window.

Source files
------------

// File: rtl/multiplier_middle_bits_seq.sv
// Sequential limb-by-limb multiplier that returns a window of the full product.
// N_DSP partial products are issued per cycle and accumulated one cycle later.
module multiplier_middle_bits_seq #(
    parameter int unsigned MUL_SIZE = 80,
    parameter int unsigned LIMB     = 20,
    parameter int unsigned N_DSP    = 4,
    parameter int unsigned LO       = 0,
    parameter int unsigned OUT_W    = 158
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                clear,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [MUL_SIZE-1:0] a,
    input  logic [MUL_SIZE-1:0] b,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [OUT_W-1:0]    res,
    output logic                busy
);

    localparam int unsigned K  = MUL_SIZE / LIMB;
    localparam int unsigned P  = (K * K) / N_DSP;
    localparam int unsigned GW = (P > 1) ? $clog2(P) : 1;
    localparam int unsigned AW = 2 * MUL_SIZE;
    localparam int unsigned PW = 2 * LIMB;

    typedef enum logic [1:0] {StIdle, StCalc, StDrain, StDone} state_e;

    state_e              state_q, state_d;
    logic [MUL_SIZE-1:0] a_q, a_d;
    logic [MUL_SIZE-1:0] b_q, b_d;
    logic [GW-1:0]       grp_q, grp_d;
    logic [GW-1:0]       pgrp_q, pgrp_d;
    logic                prod_vld_q, prod_vld_d;
    logic                drain_q, drain_d;
    logic [PW-1:0]       prod_q [N_DSP];
    logic [PW-1:0]       prod_d [N_DSP];
    logic [AW-1:0]       acc_q, acc_d;
    logic [OUT_W-1:0]    res_q, res_d;
    logic [AW-1:0]       acc_sum;

    // Bit offset of flat product index p = i*K + j within the full product.
    function automatic int unsigned limb_shift(input int unsigned p);
        return ((p / K) + (p % K)) * LIMB;
    endfunction

    always_comb begin
        acc_sum = acc_q;
        for (int unsigned n = 0; n < N_DSP; n++) begin
            acc_sum = acc_sum +
                      (AW'(prod_q[n]) << limb_shift(32'(pgrp_q) * N_DSP + n));
        end
    end

    always_comb begin
        int unsigned p;
        int unsigned li;
        int unsigned lj;
        state_d    = state_q;
        a_d        = a_q;
        b_d        = b_q;
        grp_d      = grp_q;
        pgrp_d     = pgrp_q;
        prod_vld_d = 1'b0;
        drain_d    = drain_q;
        prod_d     = prod_q;
        acc_d      = acc_q;
        res_d      = res_q;
        p          = 0;
        li         = 0;
        lj         = 0;

        if (prod_vld_q) begin
            acc_d = acc_sum;
        end

        unique case (state_q)
            StIdle: begin
                if (in_valid) begin
                    a_d     = a;
                    b_d     = b;
                    acc_d   = '0;
                    grp_d   = '0;
                    state_d = StCalc;
                end
            end
            StCalc: begin
                for (int unsigned n = 0; n < N_DSP; n++) begin
                    p         = 32'(grp_q) * N_DSP + n;
                    li        = p / K;
                    lj        = p % K;
                    prod_d[n] = {{LIMB{1'b0}}, a_q[li*LIMB +: LIMB]} *
                                {{LIMB{1'b0}}, b_q[lj*LIMB +: LIMB]};
                end
                prod_vld_d = 1'b1;
                pgrp_d     = grp_q;
                if (grp_q == GW'(P - 1)) begin
                    drain_d = 1'b0;
                    state_d = StDrain;
                end else begin
                    grp_d = grp_q + GW'(1);
                end
            end
            StDrain: begin
                // First cycle folds in the last products, second reads the settled sum.
                if (!drain_q) begin
                    drain_d = 1'b1;
                end else begin
                    res_d   = acc_q[LO +: OUT_W];
                    state_d = StDone;
                end
            end
            StDone: begin
                if (out_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase

        if (clear) begin
            state_d    = StIdle;
            prod_vld_d = 1'b0;
            drain_d    = 1'b0;
            acc_d      = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            a_q        <= '0;
            b_q        <= '0;
            grp_q      <= '0;
            pgrp_q     <= '0;
            prod_vld_q <= 1'b0;
            drain_q    <= 1'b0;
            prod_q     <= '{default: '0};
            acc_q      <= '0;
            res_q      <= '0;
        end else begin
            state_q    <= state_d;
            a_q        <= a_d;
            b_q        <= b_d;
            grp_q      <= grp_d;
            pgrp_q     <= pgrp_d;
            prod_vld_q <= prod_vld_d;
            drain_q    <= drain_d;
            prod_q     <= prod_d;
            acc_q      <= acc_d;
            res_q      <= res_d;
        end
    end

    assign in_ready  = (state_q == StIdle);
    assign busy      = (state_q != StIdle);
    assign out_valid = (state_q == StDone);
    assign res       = res_q;

endmodule

// File: tb/tb_multiplier_middle_bits_seq.sv
// Bench for multiplier_middle_bits_seq: four configurations share one stimulus stream
// and are checked against a plain a*b product window.
module tb_multiplier_middle_bits_seq;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        clear = 1'b0;
    logic        in_valid = 1'b0;
    logic        out_ready = 1'b1;
    logic [79:0] a = '0;
    logic [79:0] b = '0;

    logic [3:0]   rdys;
    logic [3:0]   ovs;
    logic [3:0]   bsy;
    logic [157:0] res0, res1, res2;
    logic [79:0]  res3;
    logic [157:0] resv [4];

    int n_vec = 0;
    int n_err = 0;

    int           exp_lat [4] = '{6, 3, 18, 6};
    int unsigned  cfg_lo  [4] = '{0, 0, 0, 80};
    int unsigned  cfg_w   [4] = '{158, 158, 158, 80};

    int           lat_g [4];
    logic [157:0] res_g [4];
    logic         rdy_g [4];
    logic         ovn_g [4];

    always #5 clk = ~clk;

    multiplier_middle_bits_seq #(.N_DSP(4)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .clear(clear), .in_valid(in_valid), .in_ready(rdys[0]),
        .a(a), .b(b), .out_valid(ovs[0]), .out_ready(out_ready), .res(res0), .busy(bsy[0])
    );
    multiplier_middle_bits_seq #(.N_DSP(16)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .clear(clear), .in_valid(in_valid), .in_ready(rdys[1]),
        .a(a), .b(b), .out_valid(ovs[1]), .out_ready(out_ready), .res(res1), .busy(bsy[1])
    );
    multiplier_middle_bits_seq #(.N_DSP(1)) u_dut2 (
        .clk(clk), .rst_n(rst_n), .clear(clear), .in_valid(in_valid), .in_ready(rdys[2]),
        .a(a), .b(b), .out_valid(ovs[2]), .out_ready(out_ready), .res(res2), .busy(bsy[2])
    );
    multiplier_middle_bits_seq #(.LO(80), .OUT_W(80)) u_dut3 (
        .clk(clk), .rst_n(rst_n), .clear(clear), .in_valid(in_valid), .in_ready(rdys[3]),
        .a(a), .b(b), .out_valid(ovs[3]), .out_ready(out_ready), .res(res3), .busy(bsy[3])
    );

    assign resv[0] = res0;
    assign resv[1] = res1;
    assign resv[2] = res2;
    assign resv[3] = {78'd0, res3};

    task automatic check_eq(input string tag, input logic [159:0] got, input logic [159:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [159:0] ref_win(input logic [79:0] av, input logic [79:0] bv,
                                             input int unsigned lo, input int unsigned w);
        logic [159:0] prod;
        logic [159:0] mask;
        prod = {80'd0, av} * {80'd0, bv};
        mask = (160'd1 << w) - 160'd1;
        return (prod >> lo) & mask;
    endfunction

    function automatic logic [79:0] rand80();
        logic [95:0] t;
        t = {$urandom(), $urandom(), $urandom()};
        case ($urandom_range(0, 7))
            0: return '1;
            1: return '0;
            2: return 80'd1 << $urandom_range(0, 79);
            default: return t[79:0];
        endcase
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Accept one operand pair on all instances and observe 22 cycles of outcome.
    task automatic run_op(input logic [79:0] av, input logic [79:0] bv);
        out_ready = 1'b1;
        in_valid  = 1'b1;
        a = av;
        b = bv;
        step();
        in_valid = 1'b0;
        a = rand80();
        b = rand80();
        for (int d = 0; d < 4; d++) begin
            lat_g[d] = -1;
            res_g[d] = '0;
            rdy_g[d] = 1'b0;
            ovn_g[d] = 1'b1;
        end
        for (int cyc = 1; cyc <= 22; cyc++) begin
            step();
            for (int d = 0; d < 4; d++) begin
                if (ovs[d] && lat_g[d] < 0) begin
                    lat_g[d] = cyc;
                    res_g[d] = resv[d];
                end else if (lat_g[d] >= 0 && cyc == lat_g[d] + 1) begin
                    rdy_g[d] = rdys[d];
                    ovn_g[d] = ovs[d];
                end
            end
        end
    endtask

    task automatic check_op(input logic [79:0] av, input logic [79:0] bv);
        for (int d = 0; d < 4; d++) begin
            check_eq($sformatf("lat%0d", d), 160'(lat_g[d]), 160'(exp_lat[d]));
            check_eq($sformatf("res%0d", d), {2'b0, res_g[d]}, ref_win(av, bv, cfg_lo[d], cfg_w[d]));
            check_eq($sformatf("rdy_after%0d", d), {159'd0, rdy_g[d]}, 160'd1);
            check_eq($sformatf("ov_after%0d", d), {159'd0, ovn_g[d]}, 160'd0);
        end
    endtask

    task automatic wait_all_idle(input string tag);
        int cnt;
        cnt = 0;
        out_ready = 1'b1;
        while (rdys != 4'hf && cnt < 40) begin
            step();
            cnt++;
        end
        check_eq(tag, {156'd0, rdys}, 160'hf);
    endtask

    initial begin
        logic [79:0]  av;
        logic [79:0]  bv;
        logic [159:0] expw;
        logic         saw;
        int           cnt;

        // Reset state while rst_n is held low.
        #2;
        check_eq("rst_ov", {156'd0, ovs}, 160'd0);
        check_eq("rst_busy", {156'd0, bsy}, 160'd0);
        check_eq("rst_rdy", {156'd0, rdys}, 160'hf);
        check_eq("rst_res0", {2'b0, res0}, 160'd0);
        check_eq("rst_res3", {80'd0, res3}, 160'd0);
        #10;
        rst_n = 1'b1;
        step();

        // a = b = 1
        run_op(80'd1, 80'd1);
        check_op(80'd1, 80'd1);
        check_eq("one_res0", {2'b0, res_g[0]}, 160'd1);

        // All-ones operands, full and middle windows.
        av = '1;
        run_op(av, av);
        check_op(av, av);
        expw = (160'd1 << 158) - (160'd1 << 81) + 160'd1;
        check_eq("ones_res0", {2'b0, res_g[0]}, expw);
        expw = (160'd1 << 80) - 160'd2;
        check_eq("ones_res3", {2'b0, res_g[3]}, expw);

        // Back-pressure in DONE with in_valid pulses that must be ignored.
        av = rand80();
        bv = rand80();
        expw = ref_win(av, bv, 0, 158);
        out_ready = 1'b0;
        in_valid = 1'b1;
        a = av;
        b = bv;
        step();
        in_valid = 1'b0;
        cnt = 0;
        while (!ovs[0] && cnt < 30) begin
            step();
            cnt++;
        end
        check_eq("stall_lat", 160'(cnt), 160'd6);
        for (int k = 0; k < 3; k++) begin
            check_eq("stall_ov", {159'd0, ovs[0]}, 160'd1);
            check_eq("stall_rdy", {159'd0, rdys[0]}, 160'd0);
            check_eq("stall_res", {2'b0, res0}, expw);
            in_valid = 1'b1;
            a = rand80();
            b = rand80();
            step();
            in_valid = 1'b0;
        end
        out_ready = 1'b1;
        step();
        check_eq("stall_rel_ov", {159'd0, ovs[0]}, 160'd0);
        check_eq("stall_rel_rdy", {159'd0, rdys[0]}, 160'd1);
        check_eq("stall_hold_res", {2'b0, res0}, expw);
        wait_all_idle("stall_idle");

        // Clear during CALC discards the operation.
        in_valid = 1'b1;
        a = rand80();
        b = rand80();
        step();
        in_valid = 1'b0;
        step();
        step();
        clear = 1'b1;
        step();
        clear = 1'b0;
        check_eq("clr_rdy", {159'd0, rdys[0]}, 160'd1);
        check_eq("clr_busy", {159'd0, bsy[0]}, 160'd0);
        check_eq("clr_rdy2", {159'd0, rdys[2]}, 160'd1);
        saw = 1'b0;
        for (int k = 0; k < 25; k++) begin
            step();
            saw = saw | (|ovs);
        end
        check_eq("clr_no_ov", {159'd0, saw}, 160'd0);
        run_op(80'd1 << 20, 80'd1 << 20);
        check_op(80'd1 << 20, 80'd1 << 20);
        check_eq("clr_next_res0", {2'b0, res_g[0]}, 160'd1 << 40);

        // Asynchronous reset mid-CALC.
        in_valid = 1'b1;
        a = rand80();
        b = rand80();
        step();
        in_valid = 1'b0;
        step();
        #2;
        rst_n = 1'b0;
        #1;
        check_eq("mrst_ov", {156'd0, ovs}, 160'd0);
        check_eq("mrst_busy", {156'd0, bsy}, 160'd0);
        check_eq("mrst_res0", {2'b0, res0}, 160'd0);
        #10;
        rst_n = 1'b1;
        saw = 1'b0;
        for (int k = 0; k < 25; k++) begin
            step();
            saw = saw | (|ovs);
        end
        check_eq("mrst_no_ov", {159'd0, saw}, 160'd0);
        check_eq("mrst_rdy", {156'd0, rdys}, 160'hf);

        // Random operands against the reference product window.
        for (int t = 0; t < 1000; t++) begin
            av = rand80();
            bv = rand80();
            run_op(av, bv);
            check_op(av, bv);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
